// File: rtl/instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_fetch_buffer
//
// Feeds the control block with instruction words. Bytes arrive one at a time
// from the input pins and are assembled little-endian (byte k lands in bits
// [8k+7:8k]) into W-bit words. Completed words go into a small FIFO, and the
// control block drains that FIFO over a valid/ready handshake.
//
// Parameters:
//   DEPTH       FIFO entries. Must be a power of two and at least 2.
//   WORD_BYTES  Bytes per instruction word. Must be at least 2.
//               The word width is W = 8*WORD_BYTES.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ena          design enable. When low, byte_stb and flush are ignored,
//                but the pop handshake still works.
//   byte_in      instruction byte from the pins
//   byte_stb     byte_in is valid this cycle
//   flush        synchronous clear of the assembler and the FIFO
//   instr_out    head-of-FIFO word (registered storage)
//   instr_valid  instr_out holds a valid word
//   instr_ready  consumer takes instr_out this cycle
//   count        number of stored words
//   full         count == DEPTH
//   overflow     sticky flag: a completed word was dropped
//   parity_err   (PARITY_CHECK_EN only) one-cycle pulse when a word is
//                discarded for bad parity
//
// Build option:
//   PARITY_CHECK_EN  When defined, each word is followed by one check byte.
//                    Bit 0 of that byte must make even parity over the data
//                    bits plus the check bit.
// ---------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter int DEPTH      = 4,
    parameter int WORD_BYTES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_stb,
    input  logic                         flush,
    output logic [8*WORD_BYTES-1:0]      instr_out,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow
`ifdef PARITY_CHECK_EN
    ,
    output logic                         parity_err
`endif
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] ST_PARITY  = 2'd2;
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]    state_reg, state_next;
    logic [IW-1:0] idx_reg,   idx_next;
    logic [W-1:0]  word_reg,  word_next;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic [W-1:0]  mem [DEPTH];

    // -----------------------------------------------------------------------
    // Qualified controls
    // -----------------------------------------------------------------------
    logic          accept;
    logic          do_flush;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          is_full;
    logic [W-1:0]  push_word;
    logic [W-1:0]  assembled;
`ifdef PARITY_CHECK_EN
    logic          parity_fail;
    logic          parity_err_reg;
`endif

    assign accept   = ena & byte_stb;
    assign do_flush = ena & flush;
    assign is_full  = (count_reg == CW'(DEPTH));

    // flush wins over everything, so a pop in a flush cycle is discarded.
    assign pop      = instr_valid & instr_ready & ~do_flush;

    // A push into a full FIFO still succeeds when the head leaves in the
    // same cycle. The write slot is then the slot being vacated.
    assign push_ok  = push_req & ~do_flush & (~is_full | pop);

    // The partial word with the incoming byte merged in at position idx.
    always_comb begin
        assembled = word_reg;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (idx_reg == IW'(k)) begin
                assembled[8*k +: 8] = byte_in;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Assembler FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        word_next   = word_reg;
        push_req    = 1'b0;
        push_word   = word_reg;
`ifdef PARITY_CHECK_EN
        parity_fail = 1'b0;
`endif
        if (accept) begin
            case (state_reg)
                ST_IDLE: begin
                    word_next  = assembled;
                    state_next = ST_COLLECT;
                    idx_next   = IW'(1);
                end
                ST_COLLECT: begin
                    if (idx_reg == IW'(WORD_BYTES - 1)) begin
`ifdef PARITY_CHECK_EN
                        // Hold the full data word until the check byte arrives.
                        word_next  = assembled;
                        state_next = ST_PARITY;
`else
                        push_req   = 1'b1;
                        push_word  = assembled;
                        word_next  = '0;
                        state_next = ST_IDLE;
`endif
                        idx_next   = '0;
                    end else begin
                        word_next  = assembled;
                        idx_next   = idx_reg + IW'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                ST_PARITY: begin
                    // Even parity: the check bit equals the XOR of the data bits.
                    if (byte_in[0] == ^word_reg) begin
                        push_req    = 1'b1;
                    end else begin
                        parity_fail = 1'b1;
                    end
                    push_word  = word_reg;
                    word_next  = '0;
                    idx_next   = '0;
                    state_next = ST_IDLE;
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                    word_next  = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage. The memory is cleared on reset so that instr_out reads 0.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                    mem[gi] <= push_word;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            word_reg       <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_reg <= 1'b0;
`endif
        end else if (do_flush) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            word_reg       <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            word_reg  <= word_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end
`ifdef PARITY_CHECK_EN
            parity_err_reg <= parity_fail;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign instr_valid = (count_reg != '0);
    assign instr_out   = mem[rd_ptr_reg];
    assign count       = count_reg;
    assign full        = is_full;
    assign overflow    = overflow_reg;
`ifdef PARITY_CHECK_EN
    assign parity_err  = parity_err_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_buffer
//
// Directed test of instr_fetch_buffer with its default parameters
// (DEPTH=4, WORD_BYTES=2). Inputs are driven and outputs are sampled 1 ns
// after each rising edge. Define PARITY_CHECK_EN for both files to cover the
// check-byte variant.
// ---------------------------------------------------------------------------
module tb_instr_fetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [7:0]  byte_in;
    logic        byte_stb;
    logic        flush;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
`ifdef PARITY_CHECK_EN
    logic        parity_err;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch_buffer #(.DEPTH(4), .WORD_BYTES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .byte_in     (byte_in),
        .byte_stb    (byte_stb),
        .flush       (flush),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .count       (count),
        .full        (full),
        .overflow    (overflow)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in  = b;
        byte_stb = 1'b1;
        step();
        byte_stb = 1'b0;
        byte_in  = 8'h00;
    endtask

    // Sends a whole word. The consumer is ready only on the completing byte
    // when rdy_last is set, so a pop can coincide with the push.
    task automatic send_word(input logic [15:0] w, input logic rdy_last);
        send_byte(w[7:0]);
`ifdef PARITY_CHECK_EN
        send_byte(w[15:8]);
        instr_ready = rdy_last;
        send_byte({7'b0, ^w});
`else
        instr_ready = rdy_last;
        send_byte(w[15:8]);
`endif
        instr_ready = 1'b0;
    endtask

    // In the parity build, completes a word whose data bytes are already in.
    task automatic finish_word(input logic [15:0] w);
`ifdef PARITY_CHECK_EN
        send_byte({7'b0, ^w});
`else
        if (w == 16'hFFFF) begin
            // Nothing to send: without a check byte the word is already complete.
        end
`endif
    endtask

    task automatic pop_one();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        byte_in     = 8'h00;
        byte_stb    = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        #1;
        // Reset state
        check("rst_valid",    32'(instr_valid), 32'd0);
        check("rst_count",    32'(count),       32'd0);
        check("rst_full",     32'(full),        32'd0);
        check("rst_overflow", 32'(overflow),    32'd0);
        check("rst_out",      32'(instr_out),   32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // First word. A partial word must stay invisible.
        send_byte(8'h34);
        check("partial_valid", 32'(instr_valid), 32'd0);
`ifdef PARITY_CHECK_EN
        send_byte(8'h12);
        finish_word(16'h1234);
`else
        send_byte(8'h12);
`endif
        check("w1_valid", 32'(instr_valid), 32'd1);
        check("w1_out",   32'(instr_out),   32'h1234);
        check("w1_count", 32'(count),       32'd1);
        step();
        check("w1_hold",  32'(instr_out),   32'h1234);
        pop_one();
        check("w1_pop_count", 32'(count),       32'd0);
        check("w1_pop_valid", 32'(instr_valid), 32'd0);

        // Fill the FIFO, then overflow it.
        for (int i = 1; i <= 4; i++) send_word(16'(i), 1'b0);
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd4);
        send_word(16'h0005, 1'b0);
        check("ovf_flag",  32'(overflow),  32'd1);
        check("ovf_count", 32'(count),     32'd4);
        check("ovf_head",  32'(instr_out), 32'h0001);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain%0d", i), 32'(instr_out), 32'(i));
            pop_one();
        end
        check("drain_count",  32'(count),    32'd0);
        check("drain_full",   32'(full),     32'd0);
        check("ovf_sticky",   32'(overflow), 32'd1);
        do_flush();
        check("flush_ovf", 32'(overflow), 32'd0);

        // Push and pop together while full.
        for (int i = 1; i <= 4; i++) send_word(16'(i), 1'b0);
        send_word(16'hBEEF, 1'b1);
        check("pp_count", 32'(count),     32'd4);
        check("pp_ovf",   32'(overflow),  32'd0);
        check("pp_full",  32'(full),      32'd1);
        check("pp_head",  32'(instr_out), 32'h0002);
        check("pp_d2",    32'(instr_out), 32'h0002);
        pop_one();
        check("pp_d3", 32'(instr_out), 32'h0003);
        pop_one();
        check("pp_d4", 32'(instr_out), 32'h0004);
        pop_one();
        check("pp_d5", 32'(instr_out), 32'hBEEF);
        pop_one();
        check("pp_empty", 32'(count), 32'd0);

        // Flush discards a partial word.
        send_byte(8'hAA);
        do_flush();
        send_word(16'h5678, 1'b0);
        check("fl_count", 32'(count),     32'd1);
        check("fl_out",   32'(instr_out), 32'h5678);
        pop_one();
        check("fl_drain", 32'(count), 32'd0);

        // Flush while count=3 and overflow=1.
        for (int i = 0; i < 5; i++) send_word(16'h0010 + 16'(i), 1'b0);
        pop_one();
        check("f3_count", 32'(count),    32'd3);
        check("f3_ovf",   32'(overflow), 32'd1);
        do_flush();
        check("f3_fl_count", 32'(count),       32'd0);
        check("f3_fl_ovf",   32'(overflow),    32'd0);
        check("f3_fl_valid", 32'(instr_valid), 32'd0);

        // ena low: bytes and flush ignored, partial word held.
        send_byte(8'hCD);
        ena = 1'b0;
        send_byte(8'h99);
        send_byte(8'h98);
        do_flush();
        check("ena_count", 32'(count), 32'd0);
        ena = 1'b1;
        send_byte(8'hAB);
        finish_word(16'hABCD);
        check("ena_count1", 32'(count),     32'd1);
        check("ena_out",    32'(instr_out), 32'hABCD);
        ena = 1'b0;
        do_flush();
        check("ena_flush_ign", 32'(count), 32'd1);
        pop_one();
        check("ena_pop", 32'(count), 32'd0);
        ena = 1'b1;

        // Asynchronous reset in the middle of a word.
        send_byte(8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count),       32'd0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        send_word(16'h1122, 1'b0);
        check("arst_w_count", 32'(count),     32'd1);
        check("arst_w_out",   32'(instr_out), 32'h1122);
        pop_one();

`ifdef PARITY_CHECK_EN
        // Good parity: 0x0003 has an even number of ones, check bit 0.
        send_byte(8'h03);
        send_byte(8'h00);
        check("par_wait", 32'(count), 32'd0);
        send_byte(8'h00);
        check("par_ok_count", 32'(count),      32'd1);
        check("par_ok_out",   32'(instr_out),  32'h0003);
        check("par_ok_err",   32'(parity_err), 32'd0);
        // Bad parity: 0x0001 needs check bit 1.
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        check("par_bad_err",   32'(parity_err), 32'd1);
        check("par_bad_count", 32'(count),      32'd1);
        step();
        check("par_err_pulse", 32'(parity_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
Upstream feed stage for the control block. Accepts a byte stream from the dedicated input pins and assembles bytes into instruction words. Buffers the words in a small FIFO and presents them to the control block over a valid/ready handshake. Decouples the slow, byte-wide pin loading from instruction consumption.

Parameters:
DEPTH, 4, FIFO entries; must be a power of two and at least 2
WORD_BYTES, 2, bytes per instruction word; word width W = 8*WORD_BYTES

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low, byte_stb and flush are ignored
byte_in  input  8  instruction byte from the pins
byte_stb  input  1  byte_in is valid this cycle (single-cycle qualifier)
flush  input  1  synchronous clear of the assembler and FIFO
instr_out  output  W  head-of-FIFO instruction word
instr_valid  output  1  instr_out holds a valid word
instr_ready  input  1  consumer accepts instr_out this cycle
count  output  $clog2(DEPTH+1)  number of stored words
full  output  1  count == DEPTH
overflow  output  1  sticky flag: a completed word was dropped

Behaviour:
- Reset is asynchronous and active-low on rst_n. All state clears: count=0, pointers=0, assembler byte index=0, partial word=0, overflow=0. Outputs on reset: instr_valid=0, full=0, count=0, overflow=0, instr_out=0 (memory is cleared).
- Assembler FSM has two states, IDLE and COLLECT, plus a byte index idx in 0..WORD_BYTES-1.
  - A byte is accepted when ena & byte_stb.
  - Bytes are little-endian: byte k goes to bits [8k+7:8k].
  - IDLE: an accepted byte stores byte 0; go to COLLECT with idx=1.
  - COLLECT: an accepted byte stores byte idx. When idx == WORD_BYTES-1, the word is complete: push is attempted and the FSM returns to IDLE with idx=0.
- Push rule: the push succeeds if count<DEPTH or a pop occurs in the same cycle. Otherwise the word is dropped, overflow sets to 1, and the FIFO is unchanged.
- Pop occurs when instr_valid & instr_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. This applies when full as well.
- instr_valid = (count != 0). instr_out = mem[rd_ptr], driven from registered storage with no combinational path from byte_in.
- Latency: if the FIFO is empty and the last byte is accepted at edge N, then instr_valid=1 and instr_out=word after edge N.
- instr_out must stay stable while instr_valid=1 and instr_ready=0.
- Pointers are log2(DEPTH) bits and wrap naturally.
- flush (qualified by ena) takes priority over everything in the same cycle. It clears count, pointers, the partial word, idx (FSM to IDLE) and overflow. The byte and pop in that cycle are discarded.
- overflow is cleared only by reset or flush.
- ena low: byte_stb and flush are ignored and the partial word is held. The pop handshake still operates.
- A partial word is never visible on instr_out.

Optional Feature:
PARITY_CHECK_EN
- Defined: after the last data byte, the FSM enters state PARITY and expects one more byte. Its bit 0 must equal the XOR of all W data bits (even parity over data plus check bit); bits 7:1 are ignored.
  - On a match, the push is attempted on that parity-byte cycle.
  - On a mismatch, the word is discarded and output parity_err pulses high for one cycle. The FIFO is unchanged and overflow is not affected.
  - The FSM returns to IDLE either way.
  - Adds port parity_err (output, 1 bit, reset 0).
- Undefined: there is no PARITY state and no parity_err port. The push happens on the last data byte, as described above.

Test Plan:
- Reset, then bytes 0x34, 0x12 with instr_ready=0 -> one edge after the 2nd byte: instr_valid=1, instr_out=0x1234, count=1. Raise instr_ready for one cycle -> count=0, instr_valid=0.
- Push 4 words 0x0001..0x0004 with ready=0 -> full=1, count=4. A 5th word 0x0005 -> dropped, overflow=1, count=4. Drain -> outputs in order 0x0001..0x0004.
- With full=1, hold ready=1 while completing word 0xBEEF -> count stays 4, the pop and push succeed, overflow stays 0, and 0xBEEF is the last word out.
- Send byte 0xAA, then flush, then bytes 0x78, 0x56 -> exactly one word 0x5678. Flush while count=3 and overflow=1 -> count=0, overflow=0.
- ena=0 during byte_stb pulses -> no state change. Assert rst_n=0 mid-word (after 1 byte), then resume -> the next two bytes form a clean word.
- PARITY_CHECK_EN: word 0x0003 with parity byte 0x00 -> stored. Word 0x0001 with parity byte 0x00 -> parity_err pulses one cycle and count is unchanged.
